// File: rtl/imem_loader.sv
// Boot-time loader: unpacks a framed byte stream into little-endian 32-bit words,
// writes them into instruction memory and releases core reset once the checksum matches.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset_n,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready;
  // rx_ready depends on the FSM state only, never on rx_valid.

  typedef enum logic [2:0] {
    SYNC   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [16:0]     CAPACITY = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] WC_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t      state;
  state_t      state_next;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  csum;
  logic        xfer;
  logic [15:0] len_full;
  logic [16:0] wc_ext;
  logic        last_word;

  assign state_dbg = state;
  assign xfer      = rx_valid && rx_ready;
  assign len_full  = {rx_data, len[7:0]};
  assign wc_ext    = {{(16 - ADDR_W){1'b0}}, word_count};
  // True when the word currently being completed is word N of the frame
  assign last_word = (wc_ext + 17'd1) == {1'b0, len};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_ready   = (state != DONE) && (state != ERR);
    case (state)
      SYNC:   if (xfer && rx_data == 8'hA5) state_next = LEN_LO;
      LEN_LO: if (xfer) state_next = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if ({1'b0, len_full} > CAPACITY) state_next = ERR;
          else if (len_full == 16'd0)      state_next = CSUM;
          else                             state_next = DATA;
        end
      end
      DATA:   if (xfer && byte_idx == 2'd3 && last_word) state_next = CSUM;
      CSUM:   if (xfer) state_next = (rx_data == csum) ? DONE : ERR;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len          <= 16'd0;
      byte_idx     <= 2'd0;
      word_buf     <= 24'd0;
      csum         <= 8'd0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= 32'd0;
      word_count   <= '0;
      core_reset_n <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (xfer) begin
        case (state)
          LEN_LO: len[7:0] <= rx_data;
          LEN_HI: begin
            len[15:8] <= rx_data;
            byte_idx  <= 2'd0;
          end
          DATA: begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                imem_we    <= 1'b1;
                imem_waddr <= word_count[ADDR_W-1:0];
                imem_wdata <= {rx_data, word_buf};
                word_count <= word_count + WC_ONE;
              end
            endcase
          end
          default: ;
        endcase
      end
      if (state_next == DONE) begin
        core_reset_n <= 1'b1;
        load_done    <= 1'b1;
      end
      if (state_next == ERR) load_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random frames on an ADDR_W=8 and an ADDR_W=2 instance,
// checked against a frame-parsing reference model.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       sel = 1'b0;

  logic        ready8, we8, crn8, done8, err8;
  logic [7:0]  addr8;
  logic [31:0] data8;
  logic [8:0]  wc8;
  logic [2:0]  st8;
  logic        ready2, we2, crn2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] data2;
  logic [2:0]  wc2;
  logic [2:0]  st2;

  logic        ready, we, crn, done, err;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [8:0]  wc;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid && !sel),
    .rx_ready(ready8), .imem_we(we8), .imem_waddr(addr8), .imem_wdata(data8),
    .core_reset_n(crn8), .load_done(done8), .load_err(err8), .word_count(wc8),
    .state_dbg(st8)
  );

  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid && sel),
    .rx_ready(ready2), .imem_we(we2), .imem_waddr(addr2), .imem_wdata(data2),
    .core_reset_n(crn2), .load_done(done2), .load_err(err2), .word_count(wc2),
    .state_dbg(st2)
  );

  assign ready = sel ? ready2 : ready8;
  assign we    = sel ? we2 : we8;
  assign addr  = sel ? {6'd0, addr2} : addr8;
  assign wdata = sel ? data2 : data8;
  assign wc    = sel ? {6'd0, wc2} : wc8;
  assign crn   = sel ? crn2 : crn8;
  assign done  = sel ? done2 : done8;
  assign err   = sel ? err2 : err8;

  int passes = 0;
  int checks = 0;
  int pulse_cnt = 0;

  always @(negedge clk) if (we) pulse_cnt <= pulse_cnt + 1;

  // Reference model output, one entry per byte of frame_q
  logic [7:0]  frame_q[$];
  bit          m_we[$];
  logic [7:0]  m_addr[$];
  logic [31:0] exp_q[$];
  logic [8:0]  m_wcq[$];
  int          m_status;  // 1 = done, 2 = error
  int          m_wc;
  int          m_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic push_entry(input bit w, input int a, input logic [31:0] d, input int c);
    m_we.push_back(w);
    m_addr.push_back(8'(a));
    exp_q.push_back(d);
    m_wcq.push_back(9'(c));
  endtask

  task automatic model_frame(input int aw);
    int i;
    int n;
    logic [7:0] x;
    logic [31:0] w;
    m_we.delete(); m_addr.delete(); exp_q.delete(); m_wcq.delete();
    i = 0;
    while (i < frame_q.size() && frame_q[i] != 8'hA5) begin
      push_entry(0, 0, 0, 0);
      i++;
    end
    for (int k = 0; k < 3; k++) push_entry(0, 0, 0, 0);
    n = int'({frame_q[i+2], frame_q[i+1]});
    i += 3;
    if (n > (1 << aw)) begin
      m_status = 2; m_wc = 0; m_len = i;
      return;
    end
    x = 8'd0;
    for (int k = 0; k < n; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) begin
        w = w | (32'(frame_q[i]) << (8 * b));
        x = x ^ frame_q[i];
        if (b == 3) push_entry(1, k, w, k + 1);
        else        push_entry(0, 0, 0, 0);
        i++;
      end
    end
    push_entry(0, 0, 0, 0);
    m_status = (frame_q[i] == x) ? 1 : 2;
    m_wc = n;
    m_len = i + 1;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", we, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input int idx);
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_we", we, 0);
      end
    end
    rx_valid = 1'b1;
    rx_data = b;
    check("ready", ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("we", we, m_we[idx]);
    if (m_we[idx]) begin
      check("waddr", addr, m_addr[idx]);
      check("wdata", wdata, exp_q[idx]);
      check("wc_step", wc, m_wcq[idx]);
    end
  endtask

  task automatic run_frame(input int aw, input bit gaps, input int max_bytes);
    int base;
    int writes;
    model_frame(aw);
    base = pulse_cnt;
    writes = 0;
    for (int i = 0; i < m_len && i < max_bytes; i++) begin
      send_byte(frame_q[i], gaps, i);
      if (m_we[i]) writes++;
    end
    if (max_bytes < m_len) return;
    if (m_status == 1) begin
      check("done", done, 1);
      check("core_rst_n", crn, 1);
      check("err", err, 0);
    end else begin
      @(posedge clk);
      #1;
      check("err", err, 1);
      check("done", done, 0);
      check("core_rst_n", crn, 0);
    end
    check("ready_end", ready, 0);
    check("wc_end", wc, m_wc);
    @(posedge clk);
    #1;
    check("pulses", pulse_cnt - base, writes);
  endtask

  task automatic base_frame(input bit garbage, input logic [7:0] last);
    logic [7:0] f[12];
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
          8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    frame_q.delete();
    if (garbage) begin
      frame_q.push_back(8'h00); frame_q.push_back(8'hFF); frame_q.push_back(8'h5A);
    end
    for (int i = 0; i < 11; i++) frame_q.push_back(f[i]);
    frame_q.push_back(last);
  endtask

  task automatic random_frame(input int n, input bit bad, input int garbage);
    logic [7:0] x;
    logic [7:0] b;
    frame_q.delete();
    for (int i = 0; i < garbage; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h00;
      frame_q.push_back(b);
    end
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n));
    frame_q.push_back(8'(n >> 8));
    x = 8'd0;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      x = x ^ b;
      frame_q.push_back(b);
    end
    if (bad) x = x ^ 8'($urandom_range(1, 255));
    frame_q.push_back(x);
  endtask

  initial begin
    sel = 1'b0;
    do_reset();
    check("rst_ready", ready, 1);
    check("rst_crn", crn, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wc", wc, 0);
    check("rst_pulses", pulse_cnt, 0);

    base_frame(0, 8'hB0);
    run_frame(8, 0, 1000);

    do_reset();
    base_frame(1, 8'hB0);
    run_frame(8, 1, 1000);

    do_reset();
    base_frame(0, 8'hB1);
    run_frame(8, 0, 1000);

    do_reset();
    base_frame(0, 8'hB0);
    run_frame(8, 0, 9);
    #3 reset_n = 1'b0;
    #1;
    check("mid_we", we, 0);
    check("mid_waddr", addr, 0);
    check("mid_wdata", wdata, 0);
    check("mid_wc", wc, 0);
    check("mid_crn", crn, 0);
    check("mid_ready", ready, 1);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(8, 0, 1000);

    sel = 1'b1;
    do_reset();
    random_frame(5, 0, 0);
    run_frame(2, 0, 1000);
    do_reset();
    random_frame(4, 0, 0);
    run_frame(2, 0, 1000);
    do_reset();
    random_frame(0, 0, 0);
    run_frame(2, 0, 1000);

    for (int t = 0; t < 8; t++) begin
      sel = t[0];
      do_reset();
      if (sel) random_frame($urandom_range(0, 5), $urandom_range(0, 3) == 0, $urandom_range(0, 2));
      else     random_frame($urandom_range(1, 8), $urandom_range(0, 3) == 0, $urandom_range(0, 3));
      run_frame(sel ? 2 : 8, $urandom_range(0, 1) == 1, 1000);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
